im_fetch_ctrl: RTL
==================

// Module: im_fetch_ctrl
// PURPOSE
//   Fetch sequencer in front of the word-addressed instruction memory (combinational read, 1024 words).
//   Owns the fetch PC and drives the IM address. Buffers fetched words in a small in-order queue.
//   Delivers {pc, instr} to decode over a valid/ready handshake; supports redirect (branch/jump) and halt.
// PARAMETERS
//   PC_RESET  32'h0000_3000  fetch PC after reset; base of the IM window
//   IM_WORDS  1024           IM depth in words; window = [PC_RESET, PC_RESET+4*IM_WORDS)
//   QDEPTH    2              instruction queue entries (>=1)
// PORTS
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   im_addr      out  32  byte address to IM (= fetch PC)
//   im_data      in   32  IM read data for im_addr, valid same cycle
//   inst_valid   out  1   queue head valid
//   inst_ready   in   1   decode accepts head this cycle
//   inst         out  32  head instruction word
//   inst_pc      out  32  head instruction address
//   redirect     in   1   flush queue and load new fetch PC
//   redirect_pc  in   32  new fetch PC; bits [1:0] forced to 0
//   halt         in   1   suspend fetching (queue still drains)
//   queue_cnt    out  $clog2(QDEPTH+1)  queued entries
//   fetch_fault  out  1   fetch PC left IM window (see CONFIGURATION)
// BEHAVIOUR
//   - Reset (reset=0, async): fpc=PC_RESET; queue empty; state=RUN. inst_valid=0, inst=0, inst_pc=0,
//     queue_cnt=0, fetch_fault=0. im_addr = fpc combinationally at all times.
//   - States: RUN, HALTED, FAULT (FAULT is reachable only with the macro).
//     RUN->HALTED when halt=1. HALTED->RUN when halt=0. FAULT exits only via reset or redirect to in-window PC.
//   - Pop: handshake = inst_valid & inst_ready at a rising edge. The head advances on the same edge.
//   - Push: allowed in RUN, redirect=0, halt=0, and (queue_cnt<QDEPTH or pop this cycle).
//     Enqueue {fpc, im_data}; fpc<=fpc+4 (32-bit wrap). Push and pop on the same edge keep queue_cnt unchanged.
//   - Latency: the first inst_valid is one cycle after reset release. Throughput is 1 instr/cycle with inst_ready=1.
//   - Stall: while inst_valid & !inst_ready, inst and inst_pc hold stable. A full queue freezes fpc.
//   - Redirect (priority over everything but reset): a same-edge pop still counts as consumed.
//     On that edge: queue is cleared; fpc<={redirect_pc[31:2],2'b00}; no push; next cycle inst_valid=0.
//     In HALTED, a redirect loads fpc and the block stays HALTED.
//   - halt and redirect together: the redirect is applied and the state becomes HALTED.
//   - Empty queue: inst, inst_pc = 0.
// CONFIGURATION
//   IM_FETCH_BOUNDS_EN defined:
//     - A push is suppressed if (fpc-PC_RESET) >= 4*IM_WORDS (unsigned); the state goes to FAULT and fetch_fault=1.
//       This includes sequential fall-off past the last word.
//     - The queue still drains.
//     - A redirect to an in-window PC clears fetch_fault and returns to RUN (or HALTED if halt=1).
//   Not defined: no window check; fpc advances freely and IM aliases on im_addr[11:2]; fetch_fault tied 0.
// TESTING
//   1) Release reset; IM word i = 32'hA000_0000+i; inst_ready=1 -> inst_valid from cycle 1;
//      inst_pc 3000,3004,3008; inst A0000000,A0000001,...
//   2) inst_ready=0 -> queue_cnt reaches 2, im_addr holds 0x3008, inst/inst_pc stable at 0x3000.
//      Raise ready -> one pop per cycle, no gap.
//   3) Queue full, redirect=1, redirect_pc=0x3103 -> next cycle queue_cnt=0, inst_valid=0;
//      following cycle inst_pc=0x3100.
//   4) halt=1 for 3 cycles with ready=1 -> queue drains to 0, fpc frozen.
//      halt=0 -> fetch resumes at the frozen fpc.
//   5) With IM_FETCH_BOUNDS_EN: redirect_pc=0x4000 -> fetch_fault=1, no push;
//      redirect_pc=0x3000 -> fault clears, inst_pc=0x3000 next.
//      Also fetch from 0x3FFC yields one instr then fault.
//      Without the macro: fetch_fault stays 0; inst_pc=0x4000 carries IM word 0.
//   6) reset=0 mid-stream (between edges) -> outputs clear immediately; after release fetch restarts at 0x3000.

Source files
------------

// File: rtl/im_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, queues {pc, instr} pairs, hands them to decode.
// Optional IM window check is enabled by defining IM_FETCH_BOUNDS_EN.
module im_fetch_ctrl #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter int unsigned IM_WORDS = 1024,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic [31:0]                    im_addr,
    input  logic [31:0]                    im_data,
    output logic                           inst_valid,
    input  logic                           inst_ready,
    output logic [31:0]                    inst,
    output logic [31:0]                    inst_pc,
    input  logic                           redirect,
    input  logic [31:0]                    redirect_pc,
    input  logic                           halt,
    output logic [$clog2(QDEPTH+1)-1:0]    queue_cnt,
    output logic                           fetch_fault
);

    localparam int unsigned   CW     = $clog2(QDEPTH + 1);
    localparam logic [CW-1:0] QFULL  = CW'(QDEPTH);
    localparam logic [31:0]   WINDOW = 32'(4 * IM_WORDS);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_HALTED = 2'd1;
    localparam logic [1:0] ST_FAULT  = 2'd2;

    logic [31:0]   fpc;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] widx;
    logic [31:0]   q_pc  [QDEPTH];
    logic [31:0]   q_ins [QDEPTH];
    logic [31:0]   redir_pc_al;
    logic          pop;
    logic          push;
    logic          win_ok;
    logic          redir_ok;

    always_comb begin
        redir_pc_al = redirect_pc & ~32'h3;
`ifdef IM_FETCH_BOUNDS_EN
        win_ok   = (fpc - PC_RESET) < WINDOW;
        redir_ok = (redir_pc_al - PC_RESET) < WINDOW;
`else
        win_ok   = 1'b1;
        redir_ok = 1'b1;
`endif
        pop  = inst_valid & inst_ready;
        push = (state == ST_RUN) && !redirect && !halt && win_ok && ((cnt < QFULL) || pop);
        widx = pop ? cnt - CW'(1) : cnt;
    end

    assign im_addr    = fpc;
    assign queue_cnt  = cnt;
    assign inst_valid = (cnt != '0);
    assign inst       = inst_valid ? q_ins[0] : '0;
    assign inst_pc    = inst_valid ? q_pc[0]  : '0;

`ifdef IM_FETCH_BOUNDS_EN
    assign fetch_fault = (state == ST_FAULT);
`else
    assign fetch_fault = 1'b0;
`endif

    // Shift queue with the head at slot 0; contents are don't-care beyond cnt, so no reset needed.
    always_ff @(posedge clk) begin
        if (pop) begin
            for (int unsigned i = 0; i + 1 < QDEPTH; i++) begin
                q_pc[i]  <= q_pc[i+1];
                q_ins[i] <= q_ins[i+1];
            end
        end
        for (int unsigned i = 0; i < QDEPTH; i++) begin
            if (push && (CW'(i) == widx)) begin
                q_pc[i]  <= fpc;
                q_ins[i] <= im_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fpc   <= PC_RESET;
            state <= ST_RUN;
            cnt   <= '0;
        end else if (redirect) begin
            cnt <= '0;
            fpc <= redir_pc_al;
            // A redirect seen while HALTED keeps the block halted; FAULT needs an in-window target.
            case (state)
                ST_FAULT:  if (redir_ok) state <= halt ? ST_HALTED : ST_RUN;
                ST_HALTED: state <= ST_HALTED;
                default:   state <= halt ? ST_HALTED : ST_RUN;
            endcase
        end else begin
            if (push)
                fpc <= fpc + 32'd4;
            if (push && !pop)
                cnt <= cnt + CW'(1);
            else if (!push && pop)
                cnt <= cnt - CW'(1);
            case (state)
                ST_RUN: begin
                    if (halt)
                        state <= ST_HALTED;
                    else if (!win_ok)
                        state <= ST_FAULT;
                end
                ST_HALTED: if (!halt) state <= ST_RUN;
                default:   state <= state;
            endcase
        end
    end

endmodule
